fifo_rd_stream: RTL
===================

# fifo_rd_stream

Read-side drain stage that sits directly downstream of the synchronous FIFO. Pops words from the FIFO whenever space allows and absorbs the FIFO's one-cycle read latency. Re-presents the words on a valid/ready stream with a 2-entry output buffer, sustaining one word per cycle under continuous `m_ready`. Also keeps a delivered-word count and a sticky underflow error for the scoreboard and status logic.

## Interface
Parameters:
- `FIFO_WIDTH`, 16, data word width; must match the FIFO.
- `CNT_WIDTH`, 32, width of the delivered-word counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_underflow`  in  1  FIFO underflow flag (read attempted while empty).
- `fifo_data_out`  in  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted `fifo_rd_en`.
- `fifo_rd_en`  out  1  FIFO read request.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  FIFO_WIDTH  output word.
- `words_out`  out  CNT_WIDTH  count of completed output handshakes.
- `underflow_err`  out  1  sticky underflow error.

## Operation
- Output buffer FSM: `EMPTY` (occ=0), `ONE` (occ=1), `TWO` (occ=2). `m_valid` = state != `EMPTY`. `m_data` is always the head entry.
- `inflight` register: set when `fifo_rd_en` is high at a clock edge; cleared otherwise. At the following edge, `fifo_data_out` is written into the buffer tail.
- Definitions:
  - `pop` = `m_valid && m_ready`.
  - `push` = `inflight`.
- `fifo_rd_en` = `rst_n && !fifo_empty && (occ + inflight - pop) < 2`. This is combinational, so `m_ready` reaches `fifo_rd_en` in the same cycle. Reads are never issued while `fifo_empty` is high.
- Transitions:
  - push only: occ+1.
  - pop only: occ-1.
  - push and pop together: occ unchanged. Head advances and the new word is written at the tail.
  - Push when occ=2 cannot occur by construction; the bench asserts this.
- Data order is strictly preserved. With push and pop in `ONE`, the incoming word becomes the new head.
- `words_out` increments on every `pop`. It wraps modulo 2^CNT_WIDTH.
- `underflow_err` sets when `fifo_underflow` is high at any edge. It stays set until reset.
- `m_valid` holds and `m_data` stays stable until `pop`. This holds regardless of `fifo_empty`.

## Timing
- Reset values:
  - `m_valid`=0, `m_data`=0, `words_out`=0, `underflow_err`=0.
  - Internal state: occ=0, `inflight`=0.
  - `fifo_rd_en`=0 while `rst_n`=0.
- Latency: `fifo_rd_en` high in cycle N, data captured at the edge ending N+1, `m_valid` high in N+2. First word therefore appears 2 cycles after `fifo_empty` falls.
- Throughput: 1 word/cycle when `m_ready` is held high and the FIFO stays non-empty.
- Backpressure:
  - With `m_ready` low, at most 2 words are held: occ plus in-flight never exceeds 2.
  - `fifo_rd_en` drops within the same cycle.
- Reset mid-operation: buffered and in-flight words are discarded immediately (asynchronously). No output appears after release until new reads complete.
- `fifo_empty` rising while a read is in flight: the in-flight word is still captured. No further reads are issued.

## Structure
- The `shared_pkg` defines:
  - the `FIFO_WIDTH` default;
  - the `buf_state_e` enum (`EMPTY`, `ONE`, `TWO`).
- Natural sub-module: `skid_buf2`, a 2-entry register FIFO with push/pop, head data and occ outputs. `fifo_rd_stream` holds the read-request logic, `inflight`, the counter and the error flag.

## Test plan
- Reset then preload FIFO with 0x0001..0x0004, `m_ready`=1 -> `fifo_rd_en` high 4 consecutive cycles; `m_data` 0x0001..0x0004 on consecutive cycles starting 2 cycles after first read; `words_out`=4.
- `m_ready`=0 with 6 words in FIFO -> exactly 2 reads issued, `fifo_rd_en` then 0, `m_data`=first word stable. Raise `m_ready` -> all 6 delivered in order with no gaps.
- FIFO empty throughout, `m_ready` toggling -> `fifo_rd_en` never asserts, `m_valid`=0, `words_out`=0.
- Assert `rst_n`=0 with occ=2 and a read in flight -> `m_valid`=0 and counters cleared immediately. After release with FIFO holding 0xAAAA, the first output is 0xAAAA.
- Force `fifo_underflow`=1 for one cycle -> `underflow_err`=1 and stays 1 until the next reset.
- Random `m_ready` (50%), 100000 cycles against a reference queue -> no loss, duplication or reordering. `words_out` matches the queue pop count modulo 2^32.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared types and defaults for the FIFO read-side drain path.
package shared_pkg;

    localparam int FIFO_WIDTH_DEF = 16;

    // Encoding equals occupancy so the state doubles as the occ count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register FIFO; head entry is always presented on head_dat_o.
// Latency: a push is visible at the head the cycle after the edge that writes it.
// Backpressure: caller must not push when full; pop while empty is ignored.
module skid_buf2
    import shared_pkg::*;
#(
    parameter int W = FIFO_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output buf_state_e   state_o,
    output logic [1:0]   occ_o
);

    buf_state_e   state_q, state_d;
    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    // slot0 is the head; on a pop the second slot shifts forward.
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case (state_q)
            EMPTY: begin
                if (push_i) begin
                    slot0_d = push_dat_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({push_i, pop_i})
                    2'b10: begin
                        slot1_d = push_dat_i;
                        state_d = TWO;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: slot0_d = push_dat_i;
                    default: ;
                endcase
            end
            TWO: begin
                if (pop_i) begin
                    slot0_d = slot1_q;
                    if (push_i) slot1_d = push_dat_i;
                    else        state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign head_dat_o = slot0_q;
    assign state_o    = state_q;
    assign occ_o      = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous FIFO onto a valid/ready stream via a 2-entry buffer.
// Latency: 2 cycles from first fifo_rd_en to m_valid; 1 word/cycle sustained.
// Backpressure: reads stop once buffered plus in-flight words would exceed 2.
module fifo_rd_stream
    import shared_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  underflow_err
);

    logic                 inflight_q;
    logic [CNT_WIDTH-1:0] words_out_q;
    logic                 underflow_err_q;
    logic                 pop;
    logic [1:0]           occ;
    logic [2:0]           level;
    buf_state_e           buf_state;

    assign pop = m_valid && m_ready;

    // Projected occupancy after this cycle; pop never exceeds occ so no underflow.
    assign level      = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = rst_n && !fifo_empty && (level < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q      <= 1'b0;
            words_out_q     <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            inflight_q      <= fifo_rd_en;
            words_out_q     <= words_out_q + {{(CNT_WIDTH-1){1'b0}}, pop};
            underflow_err_q <= underflow_err_q | fifo_underflow;
        end
    end

    skid_buf2 #(.W(FIFO_WIDTH)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (inflight_q),
        .push_dat_i (fifo_data_out),
        .pop_i      (pop),
        .head_dat_o (m_data),
        .state_o    (buf_state),
        .occ_o      (occ)
    );

    assign m_valid       = (buf_state != EMPTY);
    assign words_out     = words_out_q;
    assign underflow_err = underflow_err_q;

endmodule
